// File: rtl/sort_ram_responder_if.sv
// Request/response bundle between the sort datapath (master) and its RAM responder (slave),
// plus the host preload/dump port.
interface sort_ram_responder_if #(
   parameter int unsigned SIZE_ADDR = 8,
   parameter int unsigned SIZE_DATA = 8
);
   logic                 i_rd_en;
   logic                 i_wr_en;
   logic [SIZE_ADDR-1:0] i_addr_ram;
   logic [SIZE_DATA-1:0] i_data_ram;
   logic [SIZE_DATA-1:0] o_data_ram;
   logic                 o_rd_valid;
   logic                 o_wr_done;
   logic                 o_busy;
   logic                 o_err;
   logic                 i_host_en;
   logic                 i_host_wr;
   logic [SIZE_ADDR-1:0] i_host_addr;
   logic [SIZE_DATA-1:0] i_host_data;
   logic [SIZE_DATA-1:0] o_host_rdata;
   logic                 o_host_ack;

   modport master (
      output i_rd_en, i_wr_en, i_addr_ram, i_data_ram,
      output i_host_en, i_host_wr, i_host_addr, i_host_data,
      input  o_data_ram, o_rd_valid, o_wr_done, o_busy, o_err, o_host_rdata, o_host_ack
   );

   modport slave (
      input  i_rd_en, i_wr_en, i_addr_ram, i_data_ram,
      input  i_host_en, i_host_wr, i_host_addr, i_host_data,
      output o_data_ram, o_rd_valid, o_wr_done, o_busy, o_err, o_host_rdata, o_host_ack
   );
endinterface

// File: rtl/sort_ram_responder.sv
// RAM responder for the sort datapath with configurable read latency and a host port.
// Optional access counters are built when SORT_RAM_STATS_EN is defined.
module sort_ram_responder #(
   parameter int unsigned SIZE_ADDR  = 8,
   parameter int unsigned SIZE_DATA  = 8,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   sort_ram_responder_if.slave  bus,
   output logic [15:0]          o_rd_count,
   output logic [15:0]          o_wr_count
);
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {StIdle, StReadWait} state_e;

   state_e               state_q;
   logic [1:0]           lat_cnt_q;
   logic [SIZE_DATA-1:0] rd_pend_q;
   logic [SIZE_DATA-1:0] mem [DEPTH];

   logic                 idle, any_req, rd_accept, wr_accept, err_next;
   logic                 addr_ok, host_addr_ok, host_serve;
   logic [SIZE_DATA-1:0] mem_rdata, host_mem_rdata;

   always_comb begin
      idle           = (state_q == StIdle);
      any_req        = bus.i_rd_en | bus.i_wr_en;
      addr_ok        = 32'(bus.i_addr_ram) < DEPTH;
      host_addr_ok   = 32'(bus.i_host_addr) < DEPTH;
      wr_accept      = idle & bus.i_wr_en;
      // A simultaneous write wins; the read is dropped.
      rd_accept      = idle & bus.i_rd_en & ~bus.i_wr_en;
      host_serve     = idle & ~any_req & bus.i_host_en;
      err_next       = (~idle & any_req) | (idle & bus.i_rd_en & bus.i_wr_en) |
                       (idle & any_req & ~addr_ok);
      mem_rdata      = addr_ok ? mem[bus.i_addr_ram[IdxW-1:0]] : '0;
      host_mem_rdata = host_addr_ok ? mem[bus.i_host_addr[IdxW-1:0]] : '0;
   end

   // Storage is deliberately not reset so contents survive a reset.
   always_ff @(posedge i_clk) begin
      if (wr_accept && addr_ok) begin
         mem[bus.i_addr_ram[IdxW-1:0]] <= bus.i_data_ram;
      end else if (host_serve && bus.i_host_wr && host_addr_ok) begin
         mem[bus.i_host_addr[IdxW-1:0]] <= bus.i_host_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q          <= StIdle;
         lat_cnt_q        <= '0;
         rd_pend_q        <= '0;
         bus.o_data_ram   <= '0;
         bus.o_rd_valid   <= 1'b0;
         bus.o_wr_done    <= 1'b0;
         bus.o_err        <= 1'b0;
         bus.o_host_rdata <= '0;
         bus.o_host_ack   <= 1'b0;
      end else begin
         bus.o_rd_valid <= 1'b0;
         bus.o_wr_done  <= wr_accept;
         bus.o_err      <= err_next;
         bus.o_host_ack <= host_serve;
         if (host_serve && !bus.i_host_wr) begin
            bus.o_host_rdata <= host_mem_rdata;
         end
         unique case (state_q)
            StIdle: begin
               if (rd_accept) begin
                  if (RD_LATENCY <= 1) begin
                     bus.o_rd_valid <= 1'b1;
                     bus.o_data_ram <= mem_rdata;
                  end else begin
                     // Data is captured now; the wait only delays its delivery.
                     state_q   <= StReadWait;
                     rd_pend_q <= mem_rdata;
                     lat_cnt_q <= 2'(RD_LATENCY - 2);
                  end
               end
            end
            StReadWait: begin
               if (lat_cnt_q == 2'd0) begin
                  state_q        <= StIdle;
                  bus.o_rd_valid <= 1'b1;
                  bus.o_data_ram <= rd_pend_q;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 2'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.o_busy = (state_q == StReadWait);

`ifdef SORT_RAM_STATS_EN
   logic [15:0] rd_count_q, wr_count_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (rd_accept && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
         if (wr_accept && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end
   end

   assign o_rd_count = rd_count_q;
   assign o_wr_count = wr_count_q;
`else
   assign o_rd_count = '0;
   assign o_wr_count = '0;
`endif

endmodule

// File: tb/tb_sort_ram_responder.sv
// Scoreboard bench for sort_ram_responder (DEPTH=4, RD_LATENCY=3): stimulus queues timed
// expectations, a negedge monitor matches them against DUT strobes and probes.
module tb_sort_ram_responder;
   localparam int unsigned SizeAddr = 8;
   localparam int unsigned SizeData = 8;
   localparam int unsigned Depth    = 4;
   localparam int unsigned RdLat    = 3;
`ifdef SORT_RAM_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   localparam int KRd = 0, KWr = 1, KErr = 2, KHost = 3;
   localparam int PBusy = 0, PRdCnt = 1, PWrCnt = 2, PData = 3, PHostData = 4, PRdValid = 5,
                  PWrDone = 6, PHostAck = 7, PErr = 8;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [15:0] rd_count, wr_count;

   sort_ram_responder_if #(.SIZE_ADDR(SizeAddr), .SIZE_DATA(SizeData)) bus ();

   sort_ram_responder #(
      .SIZE_ADDR (SizeAddr),
      .SIZE_DATA (SizeData),
      .DEPTH     (Depth),
      .RD_LATENCY(RdLat)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .bus       (bus),
      .o_rd_count(rd_count),
      .o_wr_count(wr_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {int kind; int cyc; logic [7:0] data; bit chk_data;} ev_t;
   typedef struct {int sel; logic [15:0] val;} probe_t;

   ev_t    q_ev[$];
   probe_t q_probe[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   bit     done = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic string kname(int k);
      case (k)
         KRd:     return "rd_valid";
         KWr:     return "wr_done";
         KErr:    return "err";
         default: return "host_ack";
      endcase
   endfunction

   function automatic logic [15:0] probe_val(int sel);
      case (sel)
         PBusy:     return 16'(bus.o_busy);
         PRdCnt:    return rd_count;
         PWrCnt:    return wr_count;
         PData:     return 16'(bus.o_data_ram);
         PHostData: return 16'(bus.o_host_rdata);
         PRdValid:  return 16'(bus.o_rd_valid);
         PWrDone:   return 16'(bus.o_wr_done);
         PHostAck:  return 16'(bus.o_host_ack);
         default:   return 16'(bus.o_err);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   // Monitor: the only process that compares.
   always @(negedge i_clk) begin
      bit         fired [4];
      logic [7:0] act [4];
      int         idx;
      fired[KRd]   = bus.o_rd_valid;  act[KRd]   = bus.o_data_ram;
      fired[KWr]   = bus.o_wr_done;   act[KWr]   = 8'h00;
      fired[KErr]  = bus.o_err;       act[KErr]  = 8'h00;
      fired[KHost] = bus.o_host_ack;  act[KHost] = bus.o_host_rdata;
      for (int i = q_ev.size() - 1; i >= 0; i--) begin
         if (q_ev[i].cyc < cyc) begin
            chk({"missing ", kname(q_ev[i].kind)}, 32'(q_ev[i].cyc), 32'(cyc));
            q_ev.delete(i);
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (fired[k]) begin
            idx = -1;
            for (int i = 0; i < q_ev.size(); i++) begin
               if (idx < 0 && q_ev[i].kind == k && q_ev[i].cyc == cyc) idx = i;
            end
            if (idx < 0) begin
               chk({"unexpected ", kname(k)}, 32'd1, 32'd0);
            end else begin
               if (q_ev[idx].chk_data) chk({kname(k), " data"}, 32'(act[k]), 32'(q_ev[idx].data));
               else chk({kname(k), " strobe"}, 32'(fired[k]), 32'd1);
               q_ev.delete(idx);
            end
         end
      end
      foreach (q_probe[i]) begin
         chk($sformatf("probe%0d", q_probe[i].sel), 32'(probe_val(q_probe[i].sel)),
             32'(q_probe[i].val));
      end
      q_probe.delete();
      if (done) begin
         chk("queue_drained", 32'(q_ev.size()), 32'd0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_ev(input int kind, input int dly, input logic [7:0] d, input bit cd);
      q_ev.push_back(ev_t'{kind: kind, cyc: cyc + dly, data: d, chk_data: cd});
   endtask

   task automatic probe(input int sel, input logic [15:0] v);
      q_probe.push_back(probe_t'{sel: sel, val: v});
   endtask

   task automatic sreq(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
      bus.i_rd_en = rd; bus.i_wr_en = wr; bus.i_addr_ram = a; bus.i_data_ram = d;
   endtask

   task automatic hreq(input bit en, input bit wr, input logic [7:0] a, input logic [7:0] d);
      bus.i_host_en = en; bus.i_host_wr = wr; bus.i_host_addr = a; bus.i_host_data = d;
   endtask

   // Sorter read with the full latency wait; returns in the o_rd_valid cycle.
   task automatic sread(input logic [7:0] a, input logic [7:0] exp_d);
      sreq(1, 0, a, 8'h00);
      expect_ev(KRd, RdLat, exp_d, 1'b1);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      repeat (RdLat - 1) tick();
   endtask

   initial begin
      logic [7:0] pre [4];
      pre = '{8'h09, 8'h03, 8'h07, 8'h01};
      sreq(0, 0, 8'h00, 8'h00);
      hreq(0, 0, 8'h00, 8'h00);
      tick(); tick();
      for (int s = 0; s <= PErr; s++) probe(s, 16'h0000);
      i_rst_n = 1'b1;
      tick();

      // Host preload and read-back
      for (int i = 0; i < 4; i++) begin
         hreq(1, 1, 8'(i), pre[i]);
         expect_ev(KHost, 1, 8'h00, 1'b0);
         tick();
      end
      hreq(1, 0, 8'd2, 8'h00);
      expect_ev(KHost, 1, 8'h07, 1'b1);
      tick();
      hreq(0, 0, 8'h00, 8'h00);
      tick();

      // Latency 3, back-to-back read in the valid cycle
      sreq(1, 0, 8'd1, 8'h00);
      expect_ev(KRd, 3, 8'h03, 1'b1);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      probe(PBusy, 16'd1);
      tick();
      probe(PBusy, 16'd1);
      tick();
      probe(PBusy, 16'd0);
      sread(8'd3, 8'h01);

      // Write then read-after-write
      sreq(0, 1, 8'd0, 8'h01);
      expect_ev(KWr, 1, 8'h00, 1'b0);
      tick();
      sread(8'd0, 8'h01);

      // rd+wr collision: write wins, no read data
      sreq(1, 1, 8'd2, 8'h55);
      expect_ev(KWr, 1, 8'h00, 1'b0);
      expect_ev(KErr, 1, 8'h00, 1'b0);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      repeat (4) tick();

      // Requests while busy are ignored and flagged
      sreq(1, 0, 8'd1, 8'h00);
      expect_ev(KRd, 3, 8'h03, 1'b1);
      tick();
      sreq(1, 0, 8'd0, 8'h00);
      expect_ev(KErr, 1, 8'h00, 1'b0);
      tick();
      sreq(0, 1, 8'd3, 8'hAA);
      expect_ev(KErr, 1, 8'h00, 1'b0);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      tick();

      // Host waits while the sorter owns the RAM
      sreq(1, 0, 8'd3, 8'h00);
      hreq(1, 0, 8'd0, 8'h00);
      expect_ev(KRd, 3, 8'h01, 1'b1);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      tick(); tick();
      expect_ev(KHost, 1, 8'h01, 1'b1);
      tick();
      hreq(0, 0, 8'h00, 8'h00);
      tick();

      // Out-of-range sorter and host accesses
      sreq(1, 0, 8'd5, 8'h00);
      expect_ev(KErr, 1, 8'h00, 1'b0);
      expect_ev(KRd, 3, 8'h00, 1'b1);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      tick(); tick();
      sreq(0, 1, 8'd5, 8'h77);
      expect_ev(KWr, 1, 8'h00, 1'b0);
      expect_ev(KErr, 1, 8'h00, 1'b0);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      hreq(1, 0, 8'd1, 8'h00);
      expect_ev(KHost, 1, 8'h03, 1'b1);
      tick();
      hreq(1, 1, 8'd6, 8'h99);
      expect_ev(KHost, 1, 8'h00, 1'b0);
      tick();
      hreq(1, 0, 8'd6, 8'h00);
      expect_ev(KHost, 1, 8'h00, 1'b1);
      tick();
      hreq(1, 0, 8'd3, 8'h00);
      expect_ev(KHost, 1, 8'h01, 1'b1);
      tick();
      hreq(0, 0, 8'h00, 8'h00);
      probe(PRdCnt, Stats ? 16'd6 : 16'd0);
      probe(PWrCnt, Stats ? 16'd3 : 16'd0);
      tick();

      // Reset while a read is in flight
      sreq(1, 0, 8'd0, 8'h00);
      tick();
      sreq(0, 0, 8'h00, 8'h00);
      probe(PBusy, 16'd1);
      @(negedge i_clk);
      #1 i_rst_n = 1'b0;
      tick();
      probe(PBusy, 16'd0);
      probe(PRdCnt, 16'd0);
      probe(PWrCnt, 16'd0);
      probe(PRdValid, 16'd0);
      i_rst_n = 1'b1;
      repeat (4) tick();

      // Contents survive reset; counters restart
      sread(8'd2, 8'h55);
      sread(8'd3, 8'h01);
      sread(8'd0, 8'h01);
      probe(PRdCnt, Stats ? 16'd3 : 16'd0);
      probe(PWrCnt, 16'd0);
      hreq(1, 0, 8'd2, 8'h00);
      expect_ev(KHost, 1, 8'h55, 1'b1);
      tick();
      hreq(0, 0, 8'h00, 8'h00);
      repeat (4) tick();
      done = 1'b1;
   end
endmodule
